// File: rtl/serial_alu_pkg.sv
// Shared encodings for the serial bitwise ALU: operation codes and FSM states.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/bitwise_slice.sv
// Combinational SLICE-bit ripple of the per-bit AND/OR/XOR/full-add function.
module bitwise_slice
  import serial_alu_pkg::*;
#(
  parameter int SLICE = 1
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  op_e              op,
  output logic [SLICE-1:0] q,
  output logic             cout
);

  always_comb begin : ripple
    logic c;
    c = cin;
    q = '0;
    for (int i = 0; i < SLICE; i++) begin
      case (op)
        OP_ADD: begin
          q[i] = a[i] ^ b[i] ^ c;
          c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        OP_AND:  q[i] = a[i] & b[i];
        OP_OR:   q[i] = a[i] | b[i];
        default: q[i] = a[i] ^ b[i];
      endcase
    end
    // Logic ops never propagate a carry out of the slice.
    cout = (op == OP_ADD) ? c : 1'b0;
  end

endmodule

// File: rtl/serial_bitwise_alu.sv
// Multi-cycle ALU: WIDTH-bit operands consumed SLICE bits per clock through one
// bitwise_slice, with the inter-cycle carry held in a register.
module serial_bitwise_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             invb,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             zero
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_params
      $error("serial_bitwise_alu: WIDTH must be >= 2 and a multiple of SLICE");
    end
  endgenerate

  state_e             state;
  op_e                op_r;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   sa, sb, sres, res_next;
  logic [SLICE-1:0]   slice_q;
  logic               slice_cout;
  logic               accept, last;

  bitwise_slice #(.SLICE(SLICE)) u_slice (
    .a    (sa[SLICE-1:0]),
    .b    (sb[SLICE-1:0]),
    .cin  (carry),
    .op   (op_r),
    .q    (slice_q),
    .cout (slice_cout)
  );

  // New result bits enter from the MSB side; after N shifts sres holds the full word.
  assign res_next = WIDTH'({slice_q, sres} >> SLICE);
  assign last     = (cnt == CNT_W'(N - 1));
  assign accept   = start && ready;

  // Operand/result shift registers: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      sa   <= a;
      sb   <= invb ? ~b : b;
      op_r <= op_e'(op);
    end else if (state == S_RUN) begin
      sa   <= sa >> SLICE;
      sb   <= sb >> SLICE;
      sres <= res_next;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      q     <= '0;
      cout  <= 1'b0;
      zero  <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_RUN: begin
          cnt   <= cnt + 1'b1;
          carry <= slice_cout;
          if (last) begin
            state <= S_DONE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            q     <= res_next;
            cout  <= slice_cout;
            zero  <= (res_next == '0);
          end
        end
        default: begin
          if (start) begin
            state <= S_RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
            cnt   <= '0;
            carry <= (op == OP_ADD) ? cin : 1'b0;
          end else begin
            state <= S_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bitwise_alu.sv
// Scoreboard bench for serial_bitwise_alu at WIDTH/SLICE = 8/1, 8/4 and 4/2.
module tb_serial_bitwise_alu;
  import serial_alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start0, invb0, cin0;
  logic [1:0] op0;
  logic [7:0] a0, b0, q0;
  logic       ready0, busy0, done0, cout0, zero0;

  logic       start_s, cin_s, invb1;
  logic [1:0] op1;
  logic [7:0] a1, b1, q1;
  logic       ready1, busy1, done1, cout1, zero1;
  logic [3:0] a2, b2, q2;
  logic       ready2, busy2, done2, cout2, zero2;

  serial_bitwise_alu #(.WIDTH(8), .SLICE(1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .op(op0), .invb(invb0), .cin(cin0),
    .a(a0), .b(b0), .ready(ready0), .busy(busy0), .done(done0), .q(q0),
    .cout(cout0), .zero(zero0));

  serial_bitwise_alu #(.WIDTH(8), .SLICE(4)) u1 (
    .clk(clk), .rst(rst), .start(start_s), .op(op1), .invb(invb1), .cin(cin_s),
    .a(a1), .b(b1), .ready(ready1), .busy(busy1), .done(done1), .q(q1),
    .cout(cout1), .zero(zero1));

  serial_bitwise_alu #(.WIDTH(4), .SLICE(2)) u2 (
    .clk(clk), .rst(rst), .start(start_s), .op(2'b00), .invb(1'b0), .cin(cin_s),
    .a(a2), .b(b2), .ready(ready2), .busy(busy2), .done(done2), .q(q2),
    .cout(cout2), .zero(zero2));

  typedef struct {
    logic [7:0] q;
    logic       cout;
    logic       zero;
    int         acc;
  } exp_t;

  exp_t sb0[$], sb1[$], sb2[$];
  exp_t e0, e1, e2;
  logic [7:0] last_q0 = '0, last_q1 = '0, last_q2 = '0;

  int ecount = 0;
  int n_checks = 0, n_fail = 0;

  always @(posedge clk) ecount <= ecount + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, ecount);
    end
  endfunction

  // Reference: plain modular arithmetic on integers.
  function automatic exp_t model(int w, logic [1:0] op, logic invb, logic cin,
                                 logic [7:0] a, logic [7:0] b, int acc);
    exp_t e;
    int mask = (1 << w) - 1;
    int aa = int'(a) & mask;
    int bb = int'(invb ? ~b : b) & mask;
    int r;
    case (op)
      2'b00:   r = aa + bb + int'(cin);
      2'b01:   r = aa & bb;
      2'b10:   r = aa | bb;
      default: r = aa ^ bb;
    endcase
    e.q    = 8'(r & mask);
    e.cout = ((r >> w) & 1) != 0;
    e.zero = (r & mask) == 0;
    e.acc  = acc;
    return e;
  endfunction

  // Monitor for u0 (N = 8).
  always @(negedge clk) begin
    if (!rst) begin
      if (sb0.size() > 0 && ecount >= sb0[0].acc && ecount < sb0[0].acc + 8) begin
        chk("u0_run_ready", ready0, 0);
        chk("u0_run_busy", busy0, 1);
        chk("u0_run_done", done0, 0);
        chk("u0_run_hold_q", q0, last_q0);
      end
      if (done0) begin
        if (sb0.size() == 0) chk("u0_spurious_done", done0, 0);
        else begin
          e0 = sb0.pop_front();
          chk("u0_latency", ecount - e0.acc, 8);
          chk("u0_q", q0, e0.q);
          chk("u0_cout", cout0, e0.cout);
          chk("u0_zero", zero0, e0.zero);
          last_q0 = e0.q;
        end
      end else if (sb0.size() > 0 && ecount >= sb0[0].acc + 8) begin
        chk("u0_done_missing", done0, 1);
        void'(sb0.pop_front());
      end
    end
  end

  // Monitor for u1 and u2 (both N = 2).
  always @(negedge clk) begin
    if (!rst) begin
      if (sb1.size() > 0 && ecount >= sb1[0].acc && ecount < sb1[0].acc + 2) begin
        chk("u1_run_ready", ready1, 0);
        chk("u1_run_hold_q", q1, last_q1);
        chk("u2_run_busy", busy2, 1);
        chk("u2_run_hold_q", q2, last_q2[3:0]);
      end
      if (done1) begin
        if (sb1.size() == 0) chk("u1_spurious_done", done1, 0);
        else begin
          e1 = sb1.pop_front();
          chk("u1_latency", ecount - e1.acc, 2);
          chk("u1_q", q1, e1.q);
          chk("u1_cout", cout1, e1.cout);
          chk("u1_zero", zero1, e1.zero);
          last_q1 = e1.q;
        end
      end else if (sb1.size() > 0 && ecount >= sb1[0].acc + 2) begin
        chk("u1_done_missing", done1, 1);
        void'(sb1.pop_front());
      end
      if (done2) begin
        if (sb2.size() == 0) chk("u2_spurious_done", done2, 0);
        else begin
          e2 = sb2.pop_front();
          chk("u2_latency", ecount - e2.acc, 2);
          chk("u2_q", q2, e2.q[3:0]);
          chk("u2_cout", cout2, e2.cout);
          chk("u2_zero", zero2, e2.zero);
          last_q2 = e2.q;
        end
      end else if (sb2.size() > 0 && ecount >= sb2[0].acc + 2) begin
        chk("u2_done_missing", done2, 1);
        void'(sb2.pop_front());
      end
    end
  end

  task automatic issue0(logic [1:0] op, logic invb, logic cin, logic [7:0] a, logic [7:0] b);
    int guard = 0;
    while (!ready0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!ready0) chk("u0_ready_timeout", ready0, 1);
    start0 = 1'b1; op0 = op; invb0 = invb; cin0 = cin; a0 = a; b0 = b;
    sb0.push_back(model(8, op, invb, cin, a, b, ecount + 1));
    @(negedge clk);
    start0 = 1'b0;
    a0 = 8'($urandom); b0 = 8'($urandom); op0 = 2'($urandom);
    invb0 = 1'($urandom); cin0 = 1'($urandom);
  endtask

  task automatic issue12(logic [1:0] op, logic invb, logic cin, logic [7:0] a, logic [7:0] b,
                         logic [3:0] a4, logic [3:0] b4);
    int guard = 0;
    while (!(ready1 && ready2) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!(ready1 && ready2)) chk("u12_ready_timeout", ready1 & ready2, 1);
    start_s = 1'b1; op1 = op; invb1 = invb; cin_s = cin; a1 = a; b1 = b; a2 = a4; b2 = b4;
    sb1.push_back(model(8, op, invb, cin, a, b, ecount + 1));
    sb2.push_back(model(4, 2'b00, 1'b0, cin, {4'h0, a4}, {4'h0, b4}, ecount + 1));
    @(negedge clk);
    start_s = 1'b0;
    a1 = 8'($urandom); b1 = 8'($urandom); a2 = 4'($urandom); b2 = 4'($urandom);
    cin_s = 1'($urandom); op1 = 2'($urandom); invb1 = 1'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start0 = 0; op0 = 0; invb0 = 0; cin0 = 0; a0 = 0; b0 = 0;
    start_s = 0; op1 = 0; invb1 = 0; cin_s = 0; a1 = 0; b1 = 0; a2 = 0; b2 = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_q", q0, 0);
    chk("rst_cout", cout0, 0);
    chk("rst_zero", zero0, 0);
    chk("rst_ready12", ready1 & ready2, 1);
    rst = 1'b0;
    @(negedge clk);

    issue0(OP_ADD, 0, 0, 8'h5A, 8'h3C);
    repeat (10) @(negedge clk);
    issue0(OP_ADD, 0, 0, 8'hFF, 8'h01);
    issue0(OP_ADD, 1, 1, 8'h10, 8'h20);
    issue0(OP_AND, 0, 1, 8'hF0, 8'h3C);
    issue0(OP_OR,  0, 1, 8'hF0, 8'h3C);
    issue0(OP_XOR, 0, 1, 8'hF0, 8'h3C);
    issue0(OP_AND, 1, 0, 8'hF0, 8'h3C);
    repeat (10) @(negedge clk);

    // Start pulses while busy must be ignored.
    issue0(OP_ADD, 0, 0, 8'h21, 8'h42);
    @(negedge clk);
    start0 = 1'b1; @(negedge clk); start0 = 1'b0;
    @(negedge clk);
    start0 = 1'b1; @(negedge clk); start0 = 1'b0;

    // Back-to-back acceptance in the DONE cycle.
    for (int g = 0; g < 20 && !ready0; g++) @(negedge clk);
    chk("b2b_in_done", done0, 1);
    issue0(OP_ADD, 0, 0, 8'h01, 8'h01);
    repeat (10) @(negedge clk);

    // Reset in the middle of RUN aborts without a done pulse.
    issue0(OP_ADD, 0, 0, 8'hAA, 8'h55);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb0.delete(); last_q0 = '0;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", ready0, 1);
    chk("midrst_busy", busy0, 0);
    chk("midrst_q", q0, 0);
    chk("midrst_done", done0, 0);
    repeat (12) @(negedge clk);
    issue0(OP_ADD, 0, 0, 8'h03, 8'h04);

    for (int i = 0; i < 40; i++) begin
      issue0(2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    repeat (12) @(negedge clk);

    // Wider slices: directed 8/4 case, then full 4/2 ADD sweep.
    issue12(OP_ADD, 0, 1, 8'h9C, 8'h77, 4'h0, 4'h0);
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          issue12(2'($urandom), 1'($urandom), 1'(c), 8'($urandom), 8'($urandom), 4'(x), 4'(y));
    repeat (12) @(negedge clk);

    chk("sb0_drained", sb0.size(), 0);
    chk("sb1_drained", sb1.size(), 0);
    chk("sb2_drained", sb2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
